// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared FSM states, command constants and helpers for the SPI register bridge
// Contents:
//   state_t     - bridge FSM states; ACK exists only with SPI_REG_WRITE_ACK_EN
//   CMD_RD_BIT  - command bit selecting read (1) or write (0)
//   ACK_OK/ERR  - write acknowledge bytes
//   RD_OOR_VAL  - byte returned for an out-of-range read
//   addr_w()    - register index width for a given register count
package spi_reg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DREQ,
        DATA,
        RESP
`ifdef SPI_REG_WRITE_ACK_EN
        , ACK
`endif
    } state_t;

    localparam int         CMD_RD_BIT = 7;
    localparam logic [7:0] ACK_OK     = 8'hA5;
    localparam logic [7:0] ACK_ERR    = 8'hEE;
    localparam logic [7:0] RD_OOR_VAL = 8'hFF;

    function automatic int addr_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_reg_file.sv
// spi_reg_file: NUM_REGS x WIDTH register bank with one write port and a combinational read port
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (all registers to RESET_VAL)
//   we          - write enable; caller guarantees addr is in range
//   addr        - register index for both write and read
//   wdata       - write data
//   rdata       - combinational read of reg[addr]
//   regs_flat   - whole bank, reg i at [i*WIDTH +: WIDTH]
module spi_reg_file
    import spi_reg_pkg::*;
#(
    parameter int                 WIDTH     = 8,
    parameter int                 NUM_REGS  = 16,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                AW        = addr_w(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [AW-1:0]              addr,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [NUM_REGS*WIDTH-1:0]  regs_flat
);

    logic [WIDTH-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) mem[k] <= RESET_VAL;
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Out-of-range indices only occur when the caller masks the result.
    assign rdata = mem[addr];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_flat[i*WIDTH +: WIDTH] = mem[i];
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: decodes SPI RX FIFO bytes into register reads/writes, returns read data via TX FIFO
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   rx_data/rx_empty    - RX FIFO read data (valid the cycle after a pop) and empty flag
//   rx_rd_en            - RX FIFO pop pulse
//   tx_data/tx_wr_en    - TX FIFO write data and push pulse
//   tx_full             - TX FIFO full flag
//   regs_o              - flat register bank, reg i at [i*WIDTH +: WIDTH]
//   wr_stb/wr_addr      - pulse and address for each in-range write
//   err                 - sticky out-of-range address flag, cleared only by reset
// Build option: define SPI_REG_WRITE_ACK_EN to push an acknowledge byte after every write.
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               NUM_REGS  = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          rx_data,
    input  logic                      rx_empty,
    output logic                      rx_rd_en,
    output logic [WIDTH-1:0]          tx_data,
    input  logic                      tx_full,
    output logic                      tx_wr_en,
    output logic [NUM_REGS*WIDTH-1:0] regs_o,
    output logic                      wr_stb,
    output logic [6:0]                wr_addr,
    output logic                      err
);

    localparam int         AW         = addr_w(NUM_REGS);
    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    state_t           state, state_d;
    logic [WIDTH-1:0] cmd, rdata;
    logic             in_range, reg_we;

    assign in_range = {1'b0, cmd[6:0]} < NUM_REGS_B;

    spi_reg_file #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .RESET_VAL(RESET_VAL)
    ) u_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (reg_we),
        .addr     (cmd[AW-1:0]),
        .wdata    (rx_data),
        .rdata    (rdata),
        .regs_flat(regs_o)
    );

    always_comb begin
        state_d  = state;
        rx_rd_en = 1'b0;
        tx_wr_en = 1'b0;
        tx_data  = '0;
        reg_we   = 1'b0;
        case (state)
            IDLE: begin
                rx_rd_en = ~rx_empty;
                state_d  = rx_empty ? IDLE : CMD;
            end
            // The popped command byte is visible on rx_data only in this cycle.
            CMD: state_d = rx_data[CMD_RD_BIT] ? RESP : DREQ;
            DREQ: begin
                rx_rd_en = ~rx_empty;
                state_d  = rx_empty ? DREQ : DATA;
            end
            DATA: begin
                reg_we  = in_range;
`ifdef SPI_REG_WRITE_ACK_EN
                state_d = ACK;
`else
                state_d = IDLE;
`endif
            end
            RESP: begin
                tx_wr_en = ~tx_full;
                tx_data  = in_range ? rdata : RD_OOR_VAL;
                state_d  = tx_full ? RESP : IDLE;
            end
`ifdef SPI_REG_WRITE_ACK_EN
            ACK: begin
                tx_wr_en = ~tx_full;
                tx_data  = in_range ? ACK_OK : ACK_ERR;
                state_d  = tx_full ? ACK : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        // No FIFO traffic while held in reset, whatever state we came from.
        if (!rst_n) begin
            rx_rd_en = 1'b0;
            tx_wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cmd     <= '0;
            err     <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
        end else begin
            state  <= state_d;
            wr_stb <= reg_we;
            if (state == CMD) cmd <= rx_data;
            if (reg_we) wr_addr <= cmd[6:0];
            if ((state == DATA || state == RESP) && !in_range) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed bench for spi_reg_bridge against a byte-stream command model
module tb_spi_reg_bridge;

    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     rx_data = '0;
    logic           rx_empty, rx_rd_en;
    logic [7:0]     tx_data;
    logic           tx_full = 1'b0;
    logic           tx_wr_en, wr_stb, err;
    logic [N*8-1:0] regs_o;
    logic [6:0]     wr_addr;

    int tests = 0, fails = 0, cyc = 0, rel_cyc = 0;
    int rd_ptr = 0, wr_ptr = 0;
    logic [7:0]  rxbuf [256];
    logic [7:0]  shadow [128];
    logic        m_err = 1'b0;
    logic        prev_full = 1'b0;
    logic [7:0]  exp_tx [$];
    logic [14:0] exp_wr [$];
    logic [7:0]  txv [$];
    int          pops [$], pushes [$], stbs [$];

    spi_reg_bridge #(.WIDTH(8), .NUM_REGS(N), .RESET_VAL(8'h00)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_data (rx_data),
        .rx_empty(rx_empty),
        .rx_rd_en(rx_rd_en),
        .tx_data (tx_data),
        .tx_full (tx_full),
        .tx_wr_en(tx_wr_en),
        .regs_o  (regs_o),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .err     (err)
    );

    always #5 clk = ~clk;

    // RX FIFO: a byte buffer whose read data appears the cycle after a pop.
    assign rx_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (rx_rd_en) begin
            rx_data <= rxbuf[rd_ptr[7:0]];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: checks every cycle against the model's expected TX bytes and writes.
    always @(negedge clk) begin
        cyc++;
        if (prev_full && !tx_full) rel_cyc = cyc;
        prev_full = tx_full;
        if (rst_n) begin
            if (rx_rd_en) begin
                chk("rx_pop_on_empty", rx_empty, 1'b0);
                pops.push_back(cyc);
            end
            if (tx_wr_en) begin
                chk("tx_push_on_full", tx_full, 1'b0);
                pushes.push_back(cyc);
                txv.push_back(tx_data);
                if (exp_tx.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tx_unexpected: got push %0h expected none (cycle %0d)", tx_data, cyc);
                end else begin
                    chk("tx_data", tx_data, exp_tx.pop_front());
                end
            end
            if (wr_stb) begin
                stbs.push_back(cyc);
                if (exp_wr.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wr_unexpected: got wr_stb addr %0h expected none (cycle %0d)", wr_addr, cyc);
                end else begin
                    logic [14:0] e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", wr_addr, e[14:8]);
                    chk("wr_reg", regs_o[int'(e[14:8])*8 +: 8], e[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        rxbuf[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    // Model of one write command: what the stream means, independent of timing.
    task automatic model_wr(input logic [6:0] a, input logic [7:0] d);
        if (int'(a) < N) begin
            shadow[a] = d;
            exp_wr.push_back({a, d});
        end else begin
            m_err = 1'b1;
        end
`ifdef SPI_REG_WRITE_ACK_EN
        exp_tx.push_back(int'(a) < N ? 8'hA5 : 8'hEE);
`endif
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        put({1'b0, a});
        put(d);
        model_wr(a, d);
    endtask

    task automatic rd(input logic [6:0] a);
        put({1'b1, a});
        exp_tx.push_back(int'(a) < N ? shadow[a] : 8'hFF);
        if (int'(a) >= N) m_err = 1'b1;
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < N; i++) chk(name, regs_o[i*8 +: 8], shadow[i]);
        chk({name, "_err"}, err, m_err);
    endtask

    task automatic quiesce(input string name);
        int n = 0;
        while ((rd_ptr != wr_ptr || exp_tx.size() != 0 || exp_wr.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, n < 300, 1'b1);
        repeat (4) tick();
        check_regs(name);
    endtask

    task automatic clear_logs();
        pops.delete();
        pushes.delete();
        stbs.delete();
        txv.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) shadow[i] = 8'h00;
        repeat (3) tick();
        chk("rst_rx_rd_en", rx_rd_en, 1'b0);
        chk("rst_tx_wr_en", tx_wr_en, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rst_wr_stb", wr_stb, 1'b0);
        chk("rst_wr_addr", wr_addr, 7'd0);
        chk("rst_tx_data", tx_data, 8'h00);
        check_regs("rst_reg");

        // Write reg[3] = 5A
        clear_logs();
        wr(7'd3, 8'h5A);
        quiesce("wr3");
        chk("wr_stb_count", stbs.size(), 1);
        chk("wr_latency", stbs[0] - pops[0], 4);
        chk("wr_lit", regs_o[3*8 +: 8], 8'h5A);
`ifdef SPI_REG_WRITE_ACK_EN
        chk("wr_ack_count", pushes.size(), 1);
        chk("wr_ack_lit", txv[0], 8'hA5);
`else
        chk("wr_no_tx", pushes.size(), 0);
`endif

        // Read reg[3]
        clear_logs();
        rd(7'd3);
        quiesce("rd3");
        chk("rd_push_count", pushes.size(), 1);
        chk("rd_latency", pushes[0] - pops[0], 2);
        chk("rd_lit", txv[0], 8'h5A);

        // Read with TX full for 10 cycles, a write queued behind it
        tx_full = 1'b1;
        clear_logs();
        rd(7'd3);
        wr(7'd6, 8'h11);
        repeat (10) tick();
        chk("stall_pops", pops.size(), 1);
        chk("stall_pushes", pushes.size(), 0);
        tx_full = 1'b0;
        quiesce("stall");
        chk("stall_release", pushes[0] - rel_cyc, 0);
        chk("stall_lit", txv[0], 8'h5A);
        chk("stall_repop", pops[1] - pushes[0], 1);

        // Out-of-range write and read
        clear_logs();
        wr(7'h20, 8'h11);
        rd(7'h20);
        quiesce("oor");
        chk("oor_err_lit", err, 1'b1);
        chk("oor_no_stb", stbs.size(), 0);
        chk("oor_rd_lit", txv[txv.size()-1], 8'hFF);
`ifdef SPI_REG_WRITE_ACK_EN
        chk("oor_ack_lit", txv[0], 8'hEE);
`endif

        // Command, then the data byte arrives 20 cycles later
        clear_logs();
        put(8'h05);
        repeat (20) tick();
        chk("dreq_pops", pops.size(), 1);
        chk("dreq_no_stb", stbs.size(), 0);
        put(8'h77);
        model_wr(7'd5, 8'h77);
        quiesce("dreq");
        chk("dreq_lit", regs_o[5*8 +: 8], 8'h77);

        // Reset while waiting for a data byte
        wr(7'd1, 8'h42);
        quiesce("pre_rst");
        put(8'h01);
        repeat (4) tick();
        rst_n = 1'b0;
        for (int i = 0; i < 128; i++) shadow[i] = 8'h00;
        m_err = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        check_regs("mid_rst");
        chk("mid_rst_err_lit", err, 1'b0);
        clear_logs();
        rd(7'd1);
        quiesce("post_rst");
        chk("post_rst_lit", txv[0], 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
